eth_tx_framer: RTL

- Parametrised successor to the single-mode tx MAC framer. Builds complete Ethernet II frames byte-serially onto the 8-bit LocalLink-style tx interface that feeds the MAC.
- Three frame kinds: ARP request, ARP reply, and raw data frame (configurable ethertype, 2-byte length field, streamed payload).
- Adds MAC-side backpressure, minimum-frame padding and an inter-frame gap.
- Sits between the client control logic / payload FIFO and the EMAC LocalLink tx port.

---
 rtl/eth_tx_pkg.sv | 27 ++
 rtl/eth_tx_field_mux.sv | 62 ++++++
 rtl/eth_tx_framer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet II tx framer.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ARP,
        S_LEN,
        S_PAY,
        S_PAD,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        K_ARP_REQ,
        K_ARP_REP,
        K_DATA
    } kind_t;

    localparam int          ETH_HDR_LEN  = 14;
    localparam int          ARP_BODY_LEN = 28;
    localparam logic [15:0] ETHTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ARP_OP_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OP_REP   = 16'h0002;
    localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_tx_field_mux.sv
// Combinational selector for one byte of the Ethernet header or ARP body,
// chosen by frame kind and field index (fields are sent MSB first).
module eth_tx_field_mux
    import eth_tx_pkg::*;
#(
    parameter logic [47:0] SRC_MAC   = 48'h000A_3500_0001,
    parameter logic [31:0] SRC_IP    = 32'hA9FE_F299,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic [1:0]  kind,
    input  logic        arp_sel,
    input  logic [4:0]  idx,
    input  logic [47:0] arp_mac,
    input  logic [31:0] arp_ip,
    input  logic [47:0] dst_mac,
    output logic [7:0]  byte_o
);

    localparam logic [4:0] HDR_LAST = 5'(ETH_HDR_LEN - 1);
    localparam logic [4:0] ARP_LAST = 5'(ARP_BODY_LEN - 1);

    logic [47:0]  dest;
    logic [47:0]  tha;
    logic [15:0]  etype;
    logic [15:0]  oper;
    logic [111:0] hdr;
    logic [223:0] arp;
    logic [4:0]   hdr_rev;
    logic [4:0]   arp_rev;

    always_comb begin
        dest  = dst_mac;
        tha   = 48'h0;
        etype = ETHERTYPE;
        oper  = ARP_OP_REQ;
        case (kind_t'(kind))
            K_ARP_REQ: begin
                dest  = BCAST_MAC;
                etype = ETHTYPE_ARP;
            end
            K_ARP_REP: begin
                dest  = arp_mac;
                tha   = arp_mac;
                etype = ETHTYPE_ARP;
                oper  = ARP_OP_REP;
            end
            default: ;
        endcase

        hdr = {dest, SRC_MAC, etype};
        arp = {16'h0001, 16'h0800, 8'h06, 8'h04, oper, SRC_MAC, SRC_IP, tha, arp_ip};

        // Index 0 is the most significant byte, so shift by the reversed index.
        hdr_rev = HDR_LAST - idx;
        arp_rev = ARP_LAST - idx;
        if (arp_sel)
            byte_o = 8'(arp >> {arp_rev, 3'b000});
        else
            byte_o = 8'(hdr >> {hdr_rev, 3'b000});
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Byte-serial Ethernet II framer (ARP request/reply, raw data) for a LocalLink tx port.
// Define ETH_TX_PAD_EN to zero-pad short frames up to MIN_FRAME bytes.
module eth_tx_framer
    import eth_tx_pkg::*;
#(
    parameter logic [47:0] SRC_MAC    = 48'h000A_3500_0001,
    parameter logic [31:0] SRC_IP     = 32'hA9FE_F299,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          LEN_W      = 11,
    parameter int          MIN_FRAME  = 60,
    parameter int          IFG_CYCLES = 12
) (
    input  logic             clk,
    input  logic             reset,
    output logic [7:0]       tx_data,
    output logic             tx_sof,
    output logic             tx_eof,
    output logic             tx_src_rdy,
    input  logic             tx_dest_rdy,
    input  logic             arp_req,
    input  logic             arp_rep,
    input  logic [47:0]      arp_mac,
    input  logic [31:0]      arp_ip,
    input  logic             start_tx,
    input  logic [47:0]      dst_mac,
    input  logic [7:0]       data_tx,
    input  logic [LEN_W-1:0] length_tx,
    output logic             payload,
    output logic             busy
);

    localparam int CNT_W = LEN_W + 6;
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);
`ifdef ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_FRAME - 1);
    localparam logic [4:0]       HDR_LAST = 5'(ETH_HDR_LEN - 1);
    localparam logic [4:0]       ARP_LAST = 5'(ARP_BODY_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [4:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [47:0]      arp_mac_q, arp_mac_d;
    logic [31:0]      arp_ip_q, arp_ip_d;
    logic [47:0]      dst_mac_q, dst_mac_d;
    logic             src_rdy_q, src_rdy_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             busy_q, busy_d;

    logic             xfer;
    logic [CNT_W-1:0] pay_last;
    logic [15:0]      len16;
    logic [7:0]       field_byte;

    // True when the byte at (st, idx, cnt) is the final byte of the frame.
    function automatic logic is_last(state_t st, logic [4:0] idx, logic [CNT_W-1:0] cnt,
                                     logic [LEN_W-1:0] len);
        logic sect_end;
        sect_end = (st == S_ARP && idx == ARP_LAST)
                || (st == S_LEN && idx == 5'd1 && len == '0)
                || (st == S_PAY && cnt == CNT_W'(len) + CNT_W'(ETH_HDR_LEN + 1));
        if (PAD_EN)
            return (st == S_PAD && cnt == MIN_LAST) || (sect_end && cnt >= MIN_LAST);
        else
            return sect_end;
    endfunction

    assign xfer     = src_rdy_q & tx_dest_rdy;
    assign pay_last = CNT_W'(len_q) + CNT_W'(ETH_HDR_LEN + 1);
    assign len16    = 16'(len_q);

    eth_tx_field_mux #(
        .SRC_MAC   (SRC_MAC),
        .SRC_IP    (SRC_IP),
        .ETHERTYPE (ETHERTYPE)
    ) u_field_mux (
        .kind    (kind_q),
        .arp_sel (state_q == S_ARP),
        .idx     (idx_q),
        .arp_mac (arp_mac_q),
        .arp_ip  (arp_ip_q),
        .dst_mac (dst_mac_q),
        .byte_o  (field_byte)
    );

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        len_d     = len_q;
        arp_mac_d = arp_mac_q;
        arp_ip_d  = arp_ip_q;
        dst_mac_d = dst_mac_q;
        sof_d     = sof_q;

        case (state_q)
            S_IDLE: begin
                if (arp_rep || arp_req || start_tx) begin
                    kind_d    = arp_rep ? K_ARP_REP : (arp_req ? K_ARP_REQ : K_DATA);
                    arp_mac_d = arp_mac;
                    arp_ip_d  = arp_ip;
                    dst_mac_d = dst_mac;
                    len_d     = length_tx;
                    idx_d     = '0;
                    cnt_d     = '0;
                    sof_d     = 1'b1;
                    state_d   = S_HDR;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                // Byte-carrying states only advance when the MAC takes the byte.
                if (xfer) begin
                    sof_d = 1'b0;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (eof_q) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        case (state_q)
                            S_HDR: begin
                                if (idx_q == HDR_LAST) begin
                                    idx_d   = '0;
                                    state_d = (kind_q == K_DATA) ? S_LEN : S_ARP;
                                end else begin
                                    idx_d = idx_q + 5'd1;
                                end
                            end
                            S_ARP: begin
                                if (idx_q == ARP_LAST)
                                    state_d = S_PAD;
                                else
                                    idx_d = idx_q + 5'd1;
                            end
                            S_LEN: begin
                                if (idx_q == 5'd1)
                                    state_d = (len_q == '0) ? S_PAD : S_PAY;
                                else
                                    idx_d = idx_q + 5'd1;
                            end
                            S_PAY: begin
                                if (cnt_q == pay_last)
                                    state_d = S_PAD;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        eof_d     = is_last(state_d, idx_d, cnt_d, len_d);
        src_rdy_d = (state_d != S_IDLE) && (state_d != S_GAP);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            kind_q    <= K_ARP_REQ;
            idx_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            len_q     <= '0;
            arp_mac_q <= '0;
            arp_ip_q  <= '0;
            dst_mac_q <= '0;
            src_rdy_q <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            len_q     <= len_d;
            arp_mac_q <= arp_mac_d;
            arp_ip_q  <= arp_ip_d;
            dst_mac_q <= dst_mac_d;
            src_rdy_q <= src_rdy_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        case (state_q)
            S_HDR, S_ARP: tx_data = field_byte;
            S_LEN:        tx_data = idx_q[0] ? len16[7:0] : len16[15:8];
            S_PAY:        tx_data = data_tx;
            default:      tx_data = 8'h00;
        endcase
    end

    assign tx_sof     = sof_q;
    assign tx_eof     = eof_q;
    assign tx_src_rdy = src_rdy_q;
    assign busy       = busy_q;
    assign payload    = (state_q == S_PAY) && xfer;

endmodule
